data_sram_responder: RTL and testbench

//  Slave end of the core's data_sram interface (en/we/addr/wdata -> rdata next cycle).

---
 rtl/data_sram_responder.sv | 122 ++++++++++++
 tb/tb_data_sram_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder
// Function : data_sram bus slave serving a byte-writable word RAM and an MMIO
//            window (timer/compare IRQ, LED register, synchronised switches).
// Revision : 1.0
// ============================================================================
module data_sram_responder #(
  parameter int          RAM_AW  = 16,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        timer_irq
);

  localparam logic [15:0] OFF_TIMER = 16'h0000;
  localparam logic [15:0] OFF_CMP   = 16'h0004;
  localparam logic [15:0] OFF_CTRL  = 16'h0008;
  localparam logic [15:0] OFF_IRQ   = 16'h000C;
  localparam logic [15:0] OFF_LED   = 16'h0010;
  localparam logic [15:0] OFF_SW    = 16'h0014;

  logic [31:0]       mem [0:(1<<RAM_AW)-1];
  logic              is_mmio;
  logic [15:0]       offset;
  logic [RAM_AW-1:0] word_idx;
  logic              rd_req;
  logic              ram_wr;
  logic              mmio_full_wr;
  logic              timer_wr, cmp_wr, ctrl_wr, stat_wr, led_wr;
  logic              match;
  logic [31:0]       timer, timer_inc, cmp, mmio_rdata;
  logic [1:0]        ctrl;
  logic              irq_stat;
  logic [15:0]       led, sw_meta, sw_sync;
  logic [1:0]        unused_addr_lsb;

  assign unused_addr_lsb = data_sram_addr[1:0];

  assign is_mmio      = (data_sram_addr[31:16] == MMIO_HI);
  assign offset       = data_sram_addr[15:0];
  assign word_idx     = data_sram_addr[RAM_AW+1:2];
  assign rd_req       = data_sram_en && (data_sram_we == 4'h0);
  assign ram_wr       = data_sram_en && (data_sram_we != 4'h0) && !is_mmio;
  assign mmio_full_wr = data_sram_en && is_mmio && (data_sram_we == 4'hF);

  assign timer_wr = mmio_full_wr && (offset == OFF_TIMER);
  assign cmp_wr   = mmio_full_wr && (offset == OFF_CMP);
  assign ctrl_wr  = mmio_full_wr && (offset == OFF_CTRL);
  assign stat_wr  = mmio_full_wr && (offset == OFF_IRQ);
  assign led_wr   = mmio_full_wr && (offset == OFF_LED);

  // Only a genuine count step can match; a CPU write to TIMER suppresses it.
  assign timer_inc = timer + 32'd1;
  assign match     = ctrl[0] && !timer_wr && (timer_inc == cmp);

  assign led_out   = led;
  assign timer_irq = irq_stat & ctrl[1];

  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      OFF_TIMER: mmio_rdata = timer;
      OFF_CMP:   mmio_rdata = cmp;
      OFF_CTRL:  mmio_rdata = {30'h0, ctrl};
      OFF_IRQ:   mmio_rdata = {31'h0, irq_stat};
      OFF_LED:   mmio_rdata = {16'h0, led};
      OFF_SW:    mmio_rdata = {16'h0, sw_sync};
      default:   mmio_rdata = 32'h0;
    endcase
  end

  // RAM array carries no reset so its contents survive resetn.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= 32'h0;
    end else if (rd_req) begin
      data_sram_rdata <= is_mmio ? mmio_rdata : mem[word_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer    <= 32'h0;
      cmp      <= 32'hFFFF_FFFF;
      ctrl     <= 2'b00;
      irq_stat <= 1'b0;
      led      <= 16'h0;
      sw_meta  <= 16'h0;
      sw_sync  <= 16'h0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      if (timer_wr)     timer <= data_sram_wdata;
      else if (ctrl[0]) timer <= timer_inc;
      if (cmp_wr)  cmp  <= data_sram_wdata;
      if (ctrl_wr) ctrl <= data_sram_wdata[1:0];
      if (led_wr)  led  <= data_sram_wdata[15:0];
      // A match on the same edge as a W1C keeps the flag set.
      if (match)                              irq_stat <= 1'b1;
      else if (stat_wr && data_sram_wdata[0]) irq_stat <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// Bench for data_sram_responder: directed vector table, hand-written timer and
// reset sequences, then random traffic checked against a behavioural model.
module tb_data_sram_responder;

  localparam logic [31:0] MM = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] sw = 16'h0;
  logic [15:0] led;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (sw),
    .led_out         (led),
    .timer_irq       (irq)
  );

  // Reference model: architectural state updated once per clock edge.
  logic [31:0] m_ram [int];
  logic [31:0] m_timer, m_cmp, m_rdata;
  logic [1:0]  m_ctrl;
  logic        m_stat, m_rd_known;
  logic [15:0] m_led, m_s1, m_s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rdata = 32'h0; m_rd_known = 1'b1; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF;
    m_ctrl = 2'b00; m_stat = 1'b0; m_led = 16'h0; m_s1 = 16'h0; m_s2 = 16'h0;
  endtask

  task automatic model_edge(input bit e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic [15:0] s);
    bit mmio, full, t_wr, hit;
    int idx;
    logic [15:0] off;
    logic [31:0] nt, word;
    mmio = (a[31:16] == 16'hBFAF);
    idx  = int'(a[17:2]);
    off  = a[15:0];
    full = e && mmio && (w == 4'hF);
    t_wr = full && (off == 16'h0000);
    nt   = m_timer + 32'd1;
    hit  = m_ctrl[0] && !t_wr && (nt == m_cmp);
    if (e && w == 4'h0) begin
      m_rd_known = 1'b1;
      if (mmio) begin
        case (off)
          16'h0000: m_rdata = m_timer;
          16'h0004: m_rdata = m_cmp;
          16'h0008: m_rdata = {30'h0, m_ctrl};
          16'h000C: m_rdata = {31'h0, m_stat};
          16'h0010: m_rdata = {16'h0, m_led};
          16'h0014: m_rdata = {16'h0, m_s2};
          default:  m_rdata = 32'h0;
        endcase
      end else if (m_ram.exists(idx)) m_rdata = m_ram[idx];
      else m_rd_known = 1'b0;
    end
    if (e && !mmio && w != 4'h0) begin
      word = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      m_ram[idx] = word;
    end
    m_s2 = m_s1;
    m_s1 = s;
    if (t_wr) m_timer = d;
    else if (m_ctrl[0]) m_timer = nt;
    if (full && off == 16'h0004) m_cmp = d;
    if (hit) m_stat = 1'b1;
    else if (full && off == 16'h000C && d[0]) m_stat = 1'b0;
    if (full && off == 16'h0008) m_ctrl = d[1:0];
    if (full && off == 16'h0010) m_led = d[15:0];
  endtask

  // One bus cycle: drive, clock, advance model, compare outputs with model.
  task automatic cycle(input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(e, w, a, d, sw);
    #1;
    if (m_rd_known) check("model_rdata", rdata, m_rdata);
    check("model_led", {16'h0, led}, {16'h0, m_led});
    check("model_irq", {31'h0, irq}, {31'h0, m_stat & m_ctrl[1]});
    en = 1'b0; we = 4'h0;
  endtask

  typedef struct {
    bit          e;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vt [16];

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vt[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 16'h0000};
    vt[1]  = '{1'b1, 4'h1, 32'h0000_0010, 32'h0000_00AA, 32'h0000_0000, 16'h0000};
    vt[2]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h1122_33AA, 16'h0000};
    vt[3]  = '{1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1122_33AA, 16'h0000};
    vt[4]  = '{1'b1, 4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 16'h0000};
    vt[5]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 16'h0000};
    vt[6]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 16'h0000};
    vt[7]  = '{1'b1, 4'hF, MM | 32'h10,   32'hABCD_1234, 32'hDEAD_BEEF, 16'h1234};
    vt[8]  = '{1'b1, 4'h0, MM | 32'h10,   32'h0,         32'h0000_1234, 16'h1234};
    vt[9]  = '{1'b1, 4'h3, MM | 32'h10,   32'h5555_5555, 32'h0000_1234, 16'h1234};
    vt[10] = '{1'b1, 4'h0, MM | 32'h10,   32'h0,         32'h0000_1234, 16'h1234};
    vt[11] = '{1'b1, 4'h0, MM | 32'h20,   32'h0,         32'h0000_0000, 16'h1234};
    vt[12] = '{1'b1, 4'h0, MM | 32'h08,   32'h0,         32'h0000_0000, 16'h1234};
    vt[13] = '{1'b1, 4'h0, MM | 32'h04,   32'h0,         32'hFFFF_FFFF, 16'h1234};
    vt[14] = '{1'b1, 4'h0, 32'h0004_0010, 32'h0,         32'h1122_33AA, 16'h1234};
    vt[15] = '{1'b1, 4'h0, MM | 32'h14,   32'h0,         32'h0000_00F0, 16'h1234};

    // Power-on reset; asynchronous assertion must clear outputs at once.
    sw = 16'h00F0;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cycle(vt[i].e, vt[i].w, vt[i].a, vt[i].d);
      check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vt[i].exp_led});
    end

    // Compare match fires five cycles after enabling; W1C clears it.
    cycle(1'b1, 4'hF, MM | 32'h04, 32'd5);
    cycle(1'b1, 4'hF, MM | 32'h00, 32'd0);
    cycle(1'b1, 4'hF, MM | 32'h08, 32'd3);
    check("t3_irq_k0", {31'h0, irq}, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 4'h0, 32'h0, 32'h0);
      check($sformatf("t3_irq_k%0d", k), {31'h0, irq}, (k == 5) ? 32'h1 : 32'h0);
    end
    cycle(1'b1, 4'hF, MM | 32'h0C, 32'h1);
    check("t3_irq_cleared", {31'h0, irq}, 32'h0);
    cycle(1'b1, 4'hF, MM | 32'h08, 32'h0);

    // Timer wrap.
    cycle(1'b1, 4'hF, MM | 32'h00, 32'hFFFF_FFFE);
    cycle(1'b1, 4'hF, MM | 32'h08, 32'h1);
    cycle(1'b1, 4'h0, MM | 32'h00, 32'h0);
    check("t4_timer_a", rdata, 32'hFFFF_FFFE);
    cycle(1'b1, 4'h0, MM | 32'h00, 32'h0);
    check("t4_timer_b", rdata, 32'hFFFF_FFFF);
    cycle(1'b1, 4'h0, MM | 32'h00, 32'h0);
    check("t4_timer_wrap", rdata, 32'h0);

    // Match and W1C on the same edge: the flag stays set.
    cycle(1'b1, 4'hF, MM | 32'h08, 32'h0);
    cycle(1'b1, 4'hF, MM | 32'h00, 32'h10);
    cycle(1'b1, 4'hF, MM | 32'h04, 32'h20);
    cycle(1'b1, 4'hF, MM | 32'h08, 32'h3);
    check("t4_irq_pre", {31'h0, irq}, 32'h0);
    for (int k = 0; k < 15; k++) cycle(1'b0, 4'h0, 32'h0, 32'h0);
    check("t4_irq_before_match", {31'h0, irq}, 32'h0);
    cycle(1'b1, 4'hF, MM | 32'h0C, 32'h1);
    check("t4_w1c_vs_match_irq", {31'h0, irq}, 32'h1);
    cycle(1'b1, 4'h0, MM | 32'h0C, 32'h0);
    check("t4_w1c_vs_match_stat", rdata, 32'h1);

    // Reset asserted while a read is in flight.
    cycle(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    en = 1'b1; we = 4'h0; addr = 32'h0000_0010;
    @(negedge clk) resetn = 1'b0;
    model_reset();
    #1;
    check("t6_rdata", rdata, 32'h0);
    check("t6_led", {16'h0, led}, 32'h0);
    check("t6_irq", {31'h0, irq}, 32'h0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    cycle(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    check("t6_ram_kept_40", rdata, 32'hDEAD_BEEF);
    cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("t6_ram_kept_10", rdata, 32'h1122_33AA);

    // Random traffic against the model.
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
    for (int n = 0; n < 800; n++) begin
      int op;
      logic [31:0] a, d;
      logic [3:0]  w;
      op = int'($urandom_range(0, 9));
      sw = 16'($urandom);
      if (op <= 3) begin
        a = ($urandom & 32'hFFFC_0000) | (32'h100 + 32'(4 * $urandom_range(0, 7))) | 32'($urandom_range(0, 3));
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        cycle(1'b1, w, a, $urandom);
      end else if (op <= 8) begin
        a = MM | 32'(4 * $urandom_range(0, 6));
        case ($urandom_range(0, 3))
          0, 1:    w = 4'h0;
          2:       w = 4'hF;
          default: w = 4'h3;
        endcase
        d = (a[4:0] <= 5'h04) ? 32'($urandom_range(0, 40)) : $urandom;
        cycle(1'b1, w, a, d);
      end else begin
        cycle(1'b0, 4'($urandom), $urandom, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
